neuron_core_scheduler: RTL
==========================

Name: neuron_core_scheduler

Overview:
- Sequences one shared 4-input combinational neuron MAC core across NUM_NEURONS neurons of a layer.
- Holds a per-neuron weight/bias register file, written through a config port.
- Accepts one 4-element input vector per valid/ready handshake, then drives the shared core once per neuron.
- Applies ReLU to each core result and emits one result per neuron on a valid/ready output stream. Sits between the input feeder and the next layer.

Parameters:
- NUM_NEURONS, 4, neurons time-multiplexed onto the core (2..16).
- IDX_W, 2, neuron index width; must equal clog2(NUM_NEURONS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  IDX_W+3  {neuron index, field}. Field 0-3 = w0-w3, 4 = bias, 5-7 = ignored.
- cfg_data  in  8  signed weight/bias value.
- in_valid  in  1  input vector valid.
- in_ready  out  1  scheduler can accept a vector.
- in_x0, in_x1, in_x2, in_x3  in  8 each  signed input activations.
- core_x0..core_x3  out  8 each  operands to the neuron core.
- core_w0..core_w3  out  8 each  weights to the neuron core.
- core_bias  out  8  bias to the neuron core.
- core_sum  in  18  signed core result; combinational from the core_* outputs.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_idx  out  IDX_W  neuron index of the current result.
- out_data  out  18  post-ReLU result, non-negative.
- out_last  out  1  high with out_valid for neuron NUM_NEURONS-1.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset forces:
  - state=IDLE, neuron index=0.
  - All weight/bias registers and latched inputs to 0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, in_ready=1.
  - All core_* outputs to 0.
  - Reset asserted mid-operation aborts the vector. The result in flight is discarded, never emitted.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_x0..3 into input registers, clear idx to 0, go to COMPUTE.
  - COMPUTE (one cycle): core_x* = latched inputs, core_w*/core_bias = regfile[idx]. Register out_data = core_sum[17] ? 0 : core_sum. Set out_idx=idx and out_last=(idx==NUM_NEURONS-1). Go to EMIT.
  - EMIT: out_valid=1. out_data, out_idx and out_last are held stable until out_valid&&out_ready.
    - On that handshake, if idx==NUM_NEURONS-1: out_valid=0, go to IDLE.
    - Otherwise: idx+1, go to COMPUTE.
- core_* outputs are 0 in IDLE and EMIT. They are valid only in COMPUTE.
- in_ready=0 in COMPUTE and EMIT.
- Timing, for a vector accepted at the edge ending cycle T, with out_ready held at 1:
  - Neuron k result has out_valid high in cycle T+2+2k.
  - in_ready returns to 1 in cycle T+1+2*NUM_NEURONS.
- Arithmetic:
  - All operands are signed two's complement. core_sum is treated as signed 18-bit.
  - The worst case, 4*(-128*-128)+127 = 65663, fits 18 bits, so no overflow handling is needed.
  - ReLU maps any negative sum to 0 and passes a zero sum unchanged.
- Config port:
  - A write occurs at the clock edge when cfg_we=1 and busy=0.
  - cfg_we while busy=1 is silently dropped.
  - Field values 5-7 are dropped.
  - Neuron indices >= NUM_NEURONS are dropped.
- Simultaneous cfg_we and input handshake in IDLE: both take effect on the same edge, and the new weight is used for the vector just accepted.
- in_valid asserted while busy is ignored. The upstream must hold the vector until in_ready.

Optional Feature:
- Macro: NEURON_SAT_EN.
- Defined: after ReLU, out_data is clamped to 127, giving an 8-bit-safe activation for the next layer. Upper bits are zero.
- Undefined: out_data is the full 18-bit ReLU value.

Test Plan:
- Reset: assert rst for 2 cycles, including mid-EMIT -> out_valid=0, busy=0, in_ready=1, all core_* and out_* equal 0. Next vector with all weights 0 -> out_data=0.
- Positive sum: neuron0 w=1,2,3,4, bias=5, x=1,1,1,1 accepted at T -> cycle T+2: out_valid=1, out_idx=0, out_data=15.
- ReLU: neuron1 w=0xFF x4, bias=0, x=10 x4 -> core_sum=-40 -> out_idx=1, out_data=0.
- Extreme: x=-128 x4, w=-128 x4, bias=127 -> out_data=65663. With NEURON_SAT_EN -> 127.
- Backpressure: hold out_ready=0 for 5 cycles during EMIT of neuron 2 -> out_valid, out_data and out_idx stable, in_ready=0. After release, neuron 3 result follows 2 cycles later with out_last=1.
- Config while busy: cfg_we to neuron3 w0 during COMPUTE -> dropped, neuron3 result unchanged. The same write in IDLE, concurrent with in_valid -> new weight used in the current vector.

Source files
------------

// File: rtl/neuron_core_scheduler.sv
// Time-multiplexes one external 4-input neuron MAC core across NUM_NEURONS neurons of a layer.
// Latency: neuron k result is valid 2+2k cycles after the input handshake; one result per 2 cycles.
// Backpressure: out_ready low holds the result stable and stalls the sequence; in_ready low while busy.
//
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   cfg_we/addr/data      - weight/bias register file write port ({neuron, field}; field 4 = bias)
//   in_valid/ready, in_x* - 4-element signed input vector handshake
//   core_x*/w*/bias       - operands driven to the shared combinational core (non-zero only in COMPUTE)
//   core_sum              - 18-bit signed result returned by the core
//   out_valid/ready/idx/data/last - post-ReLU result stream, one beat per neuron
//   busy                  - high whenever the scheduler is not idle
// Build option: define NEURON_SAT_EN to clamp the post-ReLU result to 127.
module neuron_core_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W+2:0]   cfg_addr,
  input  logic [7:0]         cfg_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_x0,
  input  logic [7:0]         in_x1,
  input  logic [7:0]         in_x2,
  input  logic [7:0]         in_x3,
  output logic [7:0]         core_x0,
  output logic [7:0]         core_x1,
  output logic [7:0]         core_x2,
  output logic [7:0]         core_x3,
  output logic [7:0]         core_w0,
  output logic [7:0]         core_w1,
  output logic [7:0]         core_w2,
  output logic [7:0]         core_w3,
  output logic [7:0]         core_bias,
  input  logic [17:0]        core_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [17:0]        out_data,
  output logic               out_last,
  output logic               busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_x0, r_x1, r_x2, r_x3;
  logic [7:0]       r_w [NUM_NEURONS][4];
  logic [7:0]       r_b [NUM_NEURONS];
  logic [17:0]      r_out_data;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_out_last;

  logic [IDX_W-1:0] w_cfg_idx;
  logic [2:0]       w_cfg_fld;
  logic             w_cfg_wr;
  logic             w_is_last;
  logic [17:0]      w_relu;
  logic [17:0]      w_act;

  assign w_cfg_idx = cfg_addr[IDX_W+2:3];
  assign w_cfg_fld = cfg_addr[2:0];
  // Writes land only while idle; fields 5-7 and out-of-range neurons are discarded.
  assign w_cfg_wr  = cfg_we && (r_state == S_IDLE) && (w_cfg_fld < 3'd5) &&
                     ({{(32-IDX_W){1'b0}}, w_cfg_idx} < NUM_NEURONS);
  assign w_is_last = (r_idx == LAST_IDX);

  // ReLU: bit 17 is the sign of the core result; zero passes through unchanged.
  assign w_relu = core_sum[17] ? 18'd0 : core_sum;

`ifdef NEURON_SAT_EN
  assign w_act = (w_relu > 18'd127) ? 18'd127 : w_relu;
`else
  assign w_act = w_relu;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    core_x0     = 8'd0;
    core_x1     = 8'd0;
    core_x2     = 8'd0;
    core_x3     = 8'd0;
    core_w0     = 8'd0;
    core_w1     = 8'd0;
    core_w2     = 8'd0;
    core_w3     = 8'd0;
    core_bias   = 8'd0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        core_x0     = r_x0;
        core_x1     = r_x1;
        core_x2     = r_x2;
        core_x3     = r_x3;
        core_w0     = r_w[r_idx][0];
        core_w1     = r_w[r_idx][1];
        core_w2     = r_w[r_idx][2];
        core_w3     = r_w[r_idx][3];
        core_bias   = r_b[r_idx];
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = w_is_last ? S_IDLE : S_COMPUTE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: register file, latched inputs, neuron index and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_x0       <= 8'd0;
      r_x1       <= 8'd0;
      r_x2       <= 8'd0;
      r_x3       <= 8'd0;
      r_out_data <= 18'd0;
      r_out_idx  <= '0;
      r_out_last <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        r_b[n] <= 8'd0;
        for (int j = 0; j < 4; j++) begin
          r_w[n][j] <= 8'd0;
        end
      end
    end else begin
      // The register file is read only in COMPUTE, so a write on the accepting
      // edge is already visible to the vector just taken.
      if (w_cfg_wr) begin
        if (w_cfg_fld == 3'd4) begin
          r_b[w_cfg_idx] <= cfg_data;
        end else begin
          r_w[w_cfg_idx][w_cfg_fld[1:0]] <= cfg_data;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x0  <= in_x0;
            r_x1  <= in_x1;
            r_x2  <= in_x2;
            r_x3  <= in_x3;
            r_idx <= '0;
          end
        end
        S_COMPUTE: begin
          r_out_data <= w_act;
          r_out_idx  <= r_idx;
          r_out_last <= w_is_last;
        end
        S_EMIT: begin
          if (out_ready && !w_is_last) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = r_out_data;
  assign out_idx  = r_out_idx;
  assign out_last = r_out_last;

endmodule
